// File: rtl/wb_pc_ctrl_pkg.sv
// Shared definitions for the writeback / program-counter stage:
// FSM state encoding and the register-file index width.
package wb_pc_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        LOAD_WAIT = 2'd1,
        HALTED    = 2'd2
    } wb_state_e;

    localparam int REG_IDX_W = 3;

endpackage

// File: rtl/wb_pc_ctrl_pc_unit.sv
// Program counter, the pc_r1/pc_r2 shadow chain that follows instructions
// down the pipe, and the next-pc selection (absolute, relative, increment).
module wb_pc_ctrl_pc_unit #(
    parameter int A_SIZE = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc_en,
    input  logic              load_abs,
    input  logic              load_rel,
    input  logic [A_SIZE-1:0] target,
    input  logic              flush,
    output logic [A_SIZE-1:0] pc
);

    logic [A_SIZE-1:0] pc_q, pc_d;
    logic [A_SIZE-1:0] pc_r1_q, pc_r1_d;
    logic [A_SIZE-1:0] pc_r2_q, pc_r2_d;

    // Relative offsets are already A_SIZE wide, so the modulo add is the sign-extended add.
    always_comb begin
        pc_d    = pc_q;
        pc_r1_d = pc_r1_q;
        pc_r2_d = pc_r2_q;
        if (load_abs) begin
            pc_d = target;
        end else if (load_rel) begin
            pc_d = pc_r2_q + target;
        end else if (inc_en) begin
            pc_d = pc_q + A_SIZE'(1);
        end
        if (flush) begin
            pc_r1_d = '0;
            pc_r2_d = '0;
        end else if (inc_en) begin
            pc_r1_d = pc_q;
            pc_r2_d = pc_r1_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= '0;
            pc_r1_q <= '0;
            pc_r2_q <= '0;
        end else begin
            pc_q    <= pc_d;
            pc_r1_q <= pc_r1_d;
            pc_r2_q <= pc_r2_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/wb_pc_ctrl.sv
// Final pipeline stage: register writeback (including one-cycle loads),
// jump resolution with a two-cycle flush, and the terminal halt state.
module wb_pc_ctrl
    import wb_pc_ctrl_pkg::*;
#(
    parameter int D_SIZE = 32,
    parameter int A_SIZE = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [REG_IDX_W-1:0] r2_destination,
    input  logic                 r2_pc_halt,
    input  logic                 r2_pc_load,
    input  logic                 r2_pc_loadr,
    input  logic [A_SIZE-1:0]    r2_pc_target,
    input  logic                 r2_read,
    input  logic                 r2_write_en,
    input  logic [D_SIZE-1:0]    r2_result,
    input  logic [D_SIZE-1:0]    data_in,
    output logic [A_SIZE-1:0]    pc,
    output logic                 pc_flush,
    output logic                 stall,
    output logic                 mem_read,
    output logic [A_SIZE-1:0]    mem_addr,
    output logic                 wb_en,
    output logic [REG_IDX_W-1:0] wb_addr,
    output logic [D_SIZE-1:0]    wb_data,
    output logic                 halted
);

    wb_state_e            state_q, state_d;
    logic [REG_IDX_W-1:0] dest_q, dest_d;
    logic                 flush_q, flush_d;
    logic                 jump, load_abs, load_rel, inc_en;

    always_comb begin
        state_d  = state_q;
        dest_d   = dest_q;
        jump     = 1'b0;
        load_abs = 1'b0;
        load_rel = 1'b0;
        inc_en   = 1'b0;
        stall    = 1'b0;
        mem_read = 1'b0;
        mem_addr = '0;
        wb_en    = 1'b0;
        wb_addr  = '0;
        wb_data  = '0;
        case (state_q)
            RUN: begin
                if (r2_pc_halt) begin
                    state_d = HALTED;
                    wb_en   = r2_write_en;
                    wb_addr = r2_write_en ? r2_destination : '0;
                    wb_data = r2_write_en ? r2_result : '0;
                end else begin
                    jump     = r2_pc_load | r2_pc_loadr;
                    load_abs = r2_pc_load;
                    load_rel = r2_pc_loadr & ~r2_pc_load;
                    // A jump takes precedence over a load issue; its write is done as a link.
                    if (r2_read && r2_write_en && !jump) begin
                        mem_read = 1'b1;
                        mem_addr = r2_result[A_SIZE-1:0];
                        stall    = 1'b1;
                        dest_d   = r2_destination;
                        state_d  = LOAD_WAIT;
                    end else begin
                        wb_en   = r2_write_en;
                        wb_addr = r2_write_en ? r2_destination : '0;
                        wb_data = r2_write_en ? r2_result : '0;
                        inc_en  = ~jump;
                    end
                end
            end
            LOAD_WAIT: begin
                wb_en   = 1'b1;
                wb_addr = dest_q;
                wb_data = data_in;
                inc_en  = 1'b1;
                state_d = RUN;
            end
            HALTED: begin
                stall = 1'b1;
            end
            default: begin
                state_d = RUN;
            end
        endcase
        flush_d = jump;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            dest_q  <= '0;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            dest_q  <= dest_d;
            flush_q <= flush_d;
        end
    end

    assign pc_flush = jump | flush_q;
    assign halted   = (state_q == HALTED);

    wb_pc_ctrl_pc_unit #(
        .A_SIZE(A_SIZE)
    ) u_pc_unit (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_en  (inc_en),
        .load_abs(load_abs),
        .load_rel(load_rel),
        .target  (r2_pc_target),
        .flush   (pc_flush),
        .pc      (pc)
    );

endmodule

// File: tb/tb_wb_pc_ctrl.sv
// Self-checking bench for wb_pc_ctrl: a behavioural pipeline model checked
// every cycle, plus directed vectors with literal expectations.
module tb_wb_pc_ctrl;

    logic        clk;
    logic        rst_n;
    logic [2:0]  r2_destination;
    logic        r2_pc_halt;
    logic        r2_pc_load;
    logic        r2_pc_loadr;
    logic [9:0]  r2_pc_target;
    logic        r2_read;
    logic        r2_write_en;
    logic [31:0] r2_result;
    logic [31:0] data_in;
    logic [9:0]  pc;
    logic        pc_flush;
    logic        stall;
    logic        mem_read;
    logic [9:0]  mem_addr;
    logic        wb_en;
    logic [2:0]  wb_addr;
    logic [31:0] wb_data;
    logic        halted;

    int checks = 0;
    int errors = 0;

    wb_pc_ctrl #(.D_SIZE(32), .A_SIZE(10)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .r2_destination(r2_destination),
        .r2_pc_halt    (r2_pc_halt),
        .r2_pc_load    (r2_pc_load),
        .r2_pc_loadr   (r2_pc_loadr),
        .r2_pc_target  (r2_pc_target),
        .r2_read       (r2_read),
        .r2_write_en   (r2_write_en),
        .r2_result     (r2_result),
        .data_in       (data_in),
        .pc            (pc),
        .pc_flush      (pc_flush),
        .stall         (stall),
        .mem_read      (mem_read),
        .mem_addr      (mem_addr),
        .wb_en         (wb_en),
        .wb_addr       (wb_addr),
        .wb_data       (wb_data),
        .halted        (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input bit halt, input bit ld, input bit ldr, input logic [9:0] tgt,
                                 input bit rd, input bit we, input logic [2:0] dest,
                                 input logic [31:0] res, input logic [31:0] din);
        r2_pc_halt     = halt;
        r2_pc_load     = ld;
        r2_pc_loadr    = ldr;
        r2_pc_target   = tgt;
        r2_read        = rd;
        r2_write_en    = we;
        r2_destination = dest;
        r2_result      = res;
        data_in        = din;
        #1;
    endtask

    task automatic applyIdle();
        applyStimulus(0, 0, 0, 10'd0, 0, 0, 3'd0, 32'd0, 32'd0);
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Model: mode 0=running, 1=waiting for load data, 2=halted.
    // m_a1/m_a2 are the addresses of the instructions in stages 1 and 2.
    int m_mode = 0, m_pc = 0, m_a1 = 0, m_a2 = 0, m_fp = 0, m_dest = 0;
    int n_mode = 0, n_pc = 0, n_a1 = 0, n_a2 = 0, n_fp = 0, n_dest = 0;

    always @(negedge clk) begin
        int e_flush, e_stall, e_mr, e_ma, e_we, e_wa, e_halted, off;
        logic [31:0] e_wd;
        bit shift;
        if (!rst_n) begin
            m_mode = 0; m_pc = 0; m_a1 = 0; m_a2 = 0; m_fp = 0; m_dest = 0;
            n_mode = 0; n_pc = 0; n_a1 = 0; n_a2 = 0; n_fp = 0; n_dest = 0;
            checkOutput("rst_pc", 32'(pc), 0);
            checkOutput("rst_halted", 32'(halted), 0);
            checkOutput("rst_stall", 32'(stall), 0);
            checkOutput("rst_flush", 32'(pc_flush), 0);
        end else begin
            e_flush = m_fp; e_stall = 0; e_mr = 0; e_ma = 0;
            e_we = 0; e_wa = 0; e_wd = 0; e_halted = 0; shift = 0;
            n_mode = m_mode; n_pc = m_pc; n_fp = 0; n_dest = m_dest;
            if (m_mode == 0) begin
                if (r2_pc_halt) begin
                    n_mode = 2;
                    if (r2_write_en) begin e_we = 1; e_wa = r2_destination; e_wd = r2_result; end
                end else if (r2_pc_load || r2_pc_loadr) begin
                    e_flush = 1; n_fp = 1;
                    off = (r2_pc_target >= 10'd512) ? int'(r2_pc_target) - 1024 : int'(r2_pc_target);
                    n_pc = r2_pc_load ? int'(r2_pc_target) : (m_a2 + off + 1024) % 1024;
                    if (r2_write_en) begin e_we = 1; e_wa = r2_destination; e_wd = r2_result; end
                end else if (r2_read && r2_write_en) begin
                    e_mr = 1; e_ma = int'(r2_result % 1024); e_stall = 1;
                    n_dest = r2_destination; n_mode = 1;
                end else begin
                    if (r2_write_en) begin e_we = 1; e_wa = r2_destination; e_wd = r2_result; end
                    n_pc = (m_pc + 1) % 1024; shift = 1;
                end
            end else if (m_mode == 1) begin
                e_we = 1; e_wa = m_dest; e_wd = data_in;
                n_pc = (m_pc + 1) % 1024; shift = 1; n_mode = 0;
            end else begin
                e_stall = 1; e_halted = 1;
            end
            n_a1 = m_a1; n_a2 = m_a2;
            if (e_flush != 0) begin
                n_a1 = 0; n_a2 = 0;
            end else if (shift) begin
                n_a1 = m_pc; n_a2 = m_a1;
            end
            checkOutput("pc", 32'(pc), 32'(m_pc));
            checkOutput("pc_flush", 32'(pc_flush), 32'(e_flush));
            checkOutput("stall", 32'(stall), 32'(e_stall));
            checkOutput("mem_read", 32'(mem_read), 32'(e_mr));
            checkOutput("mem_addr", 32'(mem_addr), 32'(e_ma));
            checkOutput("wb_en", 32'(wb_en), 32'(e_we));
            checkOutput("wb_addr", 32'(wb_addr), 32'(e_wa));
            checkOutput("wb_data", wb_data, e_wd);
            checkOutput("halted", 32'(halted), 32'(e_halted));
        end
    end

    always @(posedge clk) begin
        if (rst_n) begin
            m_mode = n_mode; m_pc = n_pc; m_a1 = n_a1; m_a2 = n_a2; m_fp = n_fp; m_dest = n_dest;
        end
    end

    initial begin
        int guard;
        rst_n = 1'b0;
        applyIdle();
        stepCycle();
        stepCycle();
        checkOutput("lit_reset_pc", 32'(pc), 0);
        checkOutput("lit_reset_halted", 32'(halted), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            applyIdle();
            checkOutput("lit_count_pc", 32'(pc), 32'(i));
            checkOutput("lit_count_wb_en", 32'(wb_en), 0);
            stepCycle();
        end

        applyStimulus(0, 0, 0, 10'd0, 0, 1, 3'd5, 32'hDEAD_BEEF, 32'd0);
        checkOutput("lit_alu_wb_en", 32'(wb_en), 1);
        checkOutput("lit_alu_wb_addr", 32'(wb_addr), 5);
        checkOutput("lit_alu_wb_data", wb_data, 32'hDEAD_BEEF);
        stepCycle();

        applyStimulus(0, 0, 0, 10'd0, 1, 1, 3'd2, 32'h0000_0123, 32'd0);
        checkOutput("lit_load_mem_read", 32'(mem_read), 1);
        checkOutput("lit_load_mem_addr", 32'(mem_addr), 32'h123);
        checkOutput("lit_load_stall", 32'(stall), 1);
        checkOutput("lit_load_pc", 32'(pc), 6);
        stepCycle();
        applyStimulus(0, 0, 0, 10'd0, 0, 0, 3'd0, 32'd0, 32'h55);
        checkOutput("lit_loadwb_en", 32'(wb_en), 1);
        checkOutput("lit_loadwb_addr", 32'(wb_addr), 2);
        checkOutput("lit_loadwb_data", wb_data, 32'h55);
        checkOutput("lit_loadwb_mem_read", 32'(mem_read), 0);
        checkOutput("lit_loadwb_stall", 32'(stall), 0);
        stepCycle();
        applyIdle();
        checkOutput("lit_load_resume_pc", 32'(pc), 7);

        applyStimulus(0, 0, 0, 10'd0, 1, 0, 3'd4, 32'h0000_0200, 32'd0);
        checkOutput("lit_read_no_we", 32'(mem_read), 0);
        stepCycle();

        guard = 0;
        applyIdle();
        while (m_a2 != 20 && guard < 100) begin
            stepCycle();
            applyIdle();
            guard++;
        end
        checkOutput("lit_reach_pc_r2_20", 32'(guard < 100), 1);
        applyStimulus(0, 0, 1, 10'h3FC, 0, 0, 3'd0, 32'd0, 32'd0);
        checkOutput("lit_loadr_flush0", 32'(pc_flush), 1);
        stepCycle();
        applyIdle();
        checkOutput("lit_loadr_pc", 32'(pc), 16);
        checkOutput("lit_loadr_flush1", 32'(pc_flush), 1);
        stepCycle();
        applyIdle();
        checkOutput("lit_loadr_flush2", 32'(pc_flush), 0);
        checkOutput("lit_loadr_pc_next", 32'(pc), 17);

        applyStimulus(0, 1, 0, 10'd0, 0, 0, 3'd0, 32'd0, 32'd0);
        stepCycle();
        guard = 0;
        applyIdle();
        while (m_a2 != 2 && guard < 100) begin
            stepCycle();
            applyIdle();
            guard++;
        end
        checkOutput("lit_reach_pc_r2_2", 32'(guard < 100), 1);
        applyStimulus(0, 0, 1, 10'h3FC, 0, 0, 3'd0, 32'd0, 32'd0);
        stepCycle();
        applyIdle();
        checkOutput("lit_wrap_pc", 32'(pc), 1022);
        stepCycle();
        stepCycle();
        applyIdle();
        checkOutput("lit_wrap_to_zero", 32'(pc), 0);

        applyStimulus(0, 1, 1, 10'd7, 0, 0, 3'd0, 32'd0, 32'd0);
        stepCycle();
        applyStimulus(1, 0, 0, 10'd0, 0, 1, 3'd3, 32'h0000_0077, 32'd0);
        checkOutput("lit_both_pc", 32'(pc), 7);
        checkOutput("lit_halt_wb_en", 32'(wb_en), 1);
        checkOutput("lit_halt_wb_addr", 32'(wb_addr), 3);
        stepCycle();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 1, 0, 10'd100, 0, 1, 3'd6, 32'h1234, 32'd0);
            checkOutput("lit_halted", 32'(halted), 1);
            checkOutput("lit_halted_pc", 32'(pc), 7);
            checkOutput("lit_halted_wb_en", 32'(wb_en), 0);
            stepCycle();
        end

        rst_n = 1'b0;
        applyIdle();
        checkOutput("lit_rst_halt_halted", 32'(halted), 0);
        checkOutput("lit_rst_halt_pc", 32'(pc), 0);
        checkOutput("lit_rst_halt_stall", 32'(stall), 0);
        stepCycle();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyIdle();
            checkOutput("lit_after_rst_pc", 32'(pc), 32'(i));
            stepCycle();
        end

        applyStimulus(0, 0, 0, 10'd0, 1, 1, 3'd1, 32'h0000_0010, 32'd0);
        stepCycle();
        rst_n = 1'b0;
        applyStimulus(0, 0, 0, 10'd0, 0, 0, 3'd0, 32'd0, 32'h99);
        checkOutput("lit_rst_wait_wb_en", 32'(wb_en), 0);
        checkOutput("lit_rst_wait_pc", 32'(pc), 0);
        stepCycle();
        rst_n = 1'b1;
        applyIdle();
        checkOutput("lit_rst_wait_pc0", 32'(pc), 0);
        stepCycle();
        applyIdle();
        checkOutput("lit_rst_wait_pc1", 32'(pc), 1);
        stepCycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_pc_ctrl.md
# wb_pc_ctrl

Final pipeline stage and consumer of the stage-2 pipeline register bundle (destination, halt, load, loadr, target, read, write-enable, result). It owns the program counter and performs register-file writeback, including one-cycle-latency data-memory loads. It resolves absolute and relative jumps and generates the flush for the upstream pipeline registers. It also enters a terminal halt state on the halt instruction.

## Interface
- D_SIZE, 32, data width
- A_SIZE, 10, instruction/data address width
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- r2_destination  in  3  writeback register index
- r2_pc_halt  in  1  halt instruction in stage 2
- r2_pc_load  in  1  absolute jump
- r2_pc_loadr  in  1  relative jump
- r2_pc_target  in  A_SIZE  jump address (load) or two's-complement offset (loadr)
- r2_read  in  1  load: result carries memory address
- r2_write_en  in  1  instruction writes a register
- r2_result  in  D_SIZE  ALU result or load address
- data_in  in  D_SIZE  data-memory read data, valid one cycle after mem_read
- pc  out  A_SIZE  fetch address
- pc_flush  out  1  squash upstream registers (drives r2_pc_flush and r1 flush)
- stall  out  1  freeze fetch and upstream registers
- mem_read  out  1  data-memory read strobe
- mem_addr  out  A_SIZE  data-memory address
- wb_en  out  1  register-file write enable
- wb_addr  out  3  register-file write index
- wb_data  out  D_SIZE  register-file write data
- halted  out  1  core halted

## Operation
- States: RUN, LOAD_WAIT, HALTED.
- Internal PC shadow chain pc_r1, pc_r2 tracks the address of the instruction in each stage. It advances with pc when not stalled or halted. It is zeroed on flush.
- RUN, priority order:
  - r2_pc_halt: pc holds. Go to HALTED. If r2_write_en=1, the write is still performed this cycle.
  - r2_pc_load: pc <= r2_pc_target.
  - r2_pc_loadr: pc <= pc_r2 + r2_pc_target, modulo 2^A_SIZE. Offset is sign-extended to A_SIZE.
  - Both load and loadr set: load wins.
  - Either jump: pc_flush=1 this cycle and the next cycle (two-cycle bubble).
  - r2_read & r2_write_en: mem_read=1 and mem_addr=r2_result[A_SIZE-1:0]. stall=1. Capture r2_destination. Go to LOAD_WAIT.
  - r2_write_en without read: wb_en=1, wb_addr=r2_destination, wb_data=r2_result, same cycle (combinational).
  - Otherwise: pc <= pc+1, wrapping from 2^A_SIZE-1 to 0.
- r2_read without r2_write_en: ignored, treated as a no-op.
- LOAD_WAIT, one cycle:
  - wb_en=1, wb_addr=captured destination, wb_data=data_in.
  - stall=0, pc <= pc+1. Return to RUN.
  - A jump or halt in r2 is not possible here because upstream was frozen.
- HALTED: terminal.
  - pc frozen, stall=1, halted=1, all strobes 0.
  - Only rst_n exits.
- Jump and write_en together: both are performed (link-style write).

## Timing
- Reset values: pc=0, pc_r1=0, pc_r2=0, state=RUN, pc_flush=0, stall=0, mem_read=0, mem_addr=0, wb_en=0, wb_addr=0, wb_data=0, halted=0, flush delay flop=0.
- Writeback latency: ALU result written in the cycle the instruction sits in r2. A load is written one cycle later.
- pc_flush:
  - Cycle N (jump in r2) is combinational.
  - Cycle N+1 comes from a registered copy.
  - pc shows the target from cycle N+1.
- stall is combinational in the load-issue cycle. mem_read lasts exactly one cycle per load.
- Reset asserted mid-LOAD_WAIT or in HALTED: immediate return to reset values. The pending writeback is lost.

## Structure
- Shared package: state encoding (RUN=2'd0, LOAD_WAIT=2'd1, HALTED=2'd2) and the register index width constant (3). D_SIZE and A_SIZE stay module parameters.
- One natural sub-module, pc_unit: the pc register, the pc_r1/pc_r2 shadow chain and the next-pc mux. The FSM and writeback logic stay in the top module.

## Test plan
- Reset, then 4 cycles with no control inputs -> pc = 0,1,2,3,4. All strobes 0. halted=0.
- r2_write_en=1, r2_destination=5, r2_result=32'hDEAD_BEEF -> wb_en=1, wb_addr=5, wb_data=DEADBEEF in the same cycle.
- Load with r2_result=32'h0000_0123, destination 2, data_in=32'h55 on the next cycle -> mem_read=1 and mem_addr=10'h123 in the cycle with stall=1. Next cycle wb_en=1, wb_addr=2, wb_data=0x55, and pc resumes incrementing.
- r2_pc_loadr with pc_r2=10'd20 and r2_pc_target=10'h3FC (-4) -> pc=16 next cycle, pc_flush high for 2 cycles. Repeat with pc_r2=2 and offset -4 -> pc=1022 (wrap).
- r2_pc_load and r2_pc_loadr both 1, target=7 -> pc=7. Then r2_pc_halt=1 with r2_write_en=1, dest 3 -> write occurs, then halted=1 and pc frozen for 10 cycles.
- Assert rst_n=0 while in LOAD_WAIT or HALTED -> all outputs at reset values immediately. pc counts from 0 after release.
